// File: rtl/bp_pkg.sv
// bp_pkg: shared FSM states and saturating-counter helpers for the branch predictor
package bp_pkg;
  typedef enum logic {S_INIT, S_READY} state_e;
  function automatic logic [7:0] weak_nt(input int w);
    return 8'((1 << (w - 1)) - 1);
  endfunction
  function automatic logic [7:0] sat_step(input logic [7:0] v, input logic up, input int w);
    logic [7:0] mx;
    mx = 8'((1 << w) - 1);
    return up ? ((v == mx) ? v : v + 8'd1) : ((v == 8'd0) ? v : v - 8'd1);
  endfunction
endpackage

// File: rtl/bp_btb.sv
// bp_btb: tagged branch target buffer with combinational lookup, write and clear ports
module bp_btb #(
  parameter int IDX_W = 4,
  parameter int TAG_W = 8
) (
  input  logic             clk,
  input  logic [IDX_W-1:0] rd_idx,
  input  logic [TAG_W-1:0] rd_tag,
  output logic             rd_hit,
  output logic             rd_jal,
  output logic [31:0]      rd_target,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [TAG_W-1:0] wr_tag,
  input  logic [31:0]      wr_target,
  input  logic             wr_jal,
  input  logic             clr_en,
  input  logic [IDX_W-1:0] clr_idx
);
  localparam int ENTRIES = 1 << IDX_W;
  logic             valid_q [ENTRIES];
  logic             valid_d [ENTRIES];
  logic             jal_q   [ENTRIES];
  logic             jal_d   [ENTRIES];
  logic [TAG_W-1:0] tag_q   [ENTRIES];
  logic [TAG_W-1:0] tag_d   [ENTRIES];
  logic [31:0]      tgt_q   [ENTRIES];
  logic [31:0]      tgt_d   [ENTRIES];
  assign rd_hit    = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
  assign rd_jal    = jal_q[rd_idx];
  assign rd_target = tgt_q[rd_idx];
  // clear (sweep) wins over write; the two never overlap in practice
  always_comb begin
    valid_d = valid_q;
    jal_d   = jal_q;
    tag_d   = tag_q;
    tgt_d   = tgt_q;
    if (clr_en) valid_d[clr_idx] = 1'b0;
    else if (wr_en) begin
      valid_d[wr_idx] = 1'b1;
      jal_d[wr_idx]   = wr_jal;
      tag_d[wr_idx]   = wr_tag;
      tgt_d[wr_idx]   = wr_target;
    end
  end
  // table storage; validity is established by the clear sweep, not by reset
  always_ff @(posedge clk) begin
    valid_q <= valid_d;
    jal_q   <= jal_d;
    tag_q   <= tag_d;
    tgt_q   <= tgt_d;
  end
endmodule

// File: rtl/branch_predictor_2lvl.sv
// branch_predictor_2lvl: two-level local-history predictor with tagged BTB and clear sweep
module branch_predictor_2lvl
  import bp_pkg::*;
#(
  parameter int IDX_W  = 4,
  parameter int HIST_W = 4,
  parameter int CTR_W  = 2,
  parameter int TAG_W  = 8,
  parameter int STAT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  output logic              busy,
  input  logic [31:0]       pred_pc,
  output logic              pred_taken,
  output logic              pred_hit,
  output logic [31:0]       pred_target,
  input  logic              upd_valid,
  input  logic [31:0]       upd_pc,
  input  logic              upd_is_jal,
  input  logic              upd_taken,
  input  logic [31:0]       upd_target,
  input  logic              upd_pred_taken,
  output logic [STAT_W-1:0] stat_branches,
  output logic [STAT_W-1:0] stat_mispred
);
  localparam int ENTRIES = 1 << IDX_W;
  localparam int TAG_LO  = IDX_W + 2;
  state_e              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [HIST_W-1:0]   bhr_q [ENTRIES];
  logic [HIST_W-1:0]   bhr_d [ENTRIES];
  logic [CTR_W-1:0]    pht_q [ENTRIES];
  logic [CTR_W-1:0]    pht_d [ENTRIES];
  logic [STAT_W-1:0]   br_q, br_d, mis_q, mis_d;
  logic [IDX_W-1:0]    pi, pp, ui, up;
  logic                btb_hit, btb_jal, upd_ok;
  logic [31:0]         btb_target;
  logic                unused_pc_bits;
  assign unused_pc_bits = ^{pred_pc[1:0], pred_pc[31:TAG_LO+TAG_W], upd_pc[1:0], upd_pc[31:TAG_LO+TAG_W]};
  assign busy          = (state_q == S_INIT);
  assign pi            = pred_pc[IDX_W+1:2];
  assign pp            = pi ^ IDX_W'(bhr_q[pi]);
  assign ui            = upd_pc[IDX_W+1:2];
  assign up            = ui ^ IDX_W'(bhr_q[ui]);
  assign upd_ok        = upd_valid && !busy && !flush;
  assign pred_hit      = !busy && btb_hit;
  assign pred_taken    = pred_hit && (btb_jal || pht_q[pp][CTR_W-1]);
  assign pred_target   = pred_hit ? btb_target : 32'd0;
  assign stat_branches = br_q;
  assign stat_mispred  = mis_q;
  bp_btb #(.IDX_W(IDX_W), .TAG_W(TAG_W)) u_btb (
    .clk       (clk),
    .rd_idx    (pi),
    .rd_tag    (pred_pc[TAG_LO+TAG_W-1:TAG_LO]),
    .rd_hit    (btb_hit),
    .rd_jal    (btb_jal),
    .rd_target (btb_target),
    .wr_en     (upd_ok && upd_taken),
    .wr_idx    (ui),
    .wr_tag    (upd_pc[TAG_LO+TAG_W-1:TAG_LO]),
    .wr_target (upd_target),
    .wr_jal    (upd_is_jal),
    .clr_en    (busy),
    .clr_idx   (idx_q)
  );
  // sweep sequencing: flush restarts at index 0, last index hands over to READY
  always_comb begin
    state_d = flush ? S_INIT : (busy && (&idx_q)) ? S_READY : state_q;
    idx_d   = flush ? '0 : busy ? idx_q + 1'b1 : idx_q;
  end
  // table clear during the sweep, otherwise branch training and statistics
  always_comb begin
    bhr_d = bhr_q;
    pht_d = pht_q;
    br_d  = br_q;
    mis_d = mis_q;
    if (busy) begin
      bhr_d[idx_q] = '0;
      pht_d[idx_q] = CTR_W'(weak_nt(CTR_W));
    end else if (upd_ok && !upd_is_jal) begin
      pht_d[up] = CTR_W'(sat_step(8'(pht_q[up]), upd_taken, CTR_W));
      bhr_d[ui] = {bhr_q[ui][HIST_W-2:0], upd_taken};
      br_d      = br_q + 1'b1;
      mis_d     = mis_q + STAT_W'(upd_taken != upd_pred_taken);
    end
  end
  // control state and statistics; reset starts a fresh sweep and zeroes the counters
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_INIT;
      idx_q   <= '0;
      br_q    <= '0;
      mis_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      br_q    <= br_d;
      mis_q   <= mis_d;
    end
  end
  // history and counter tables, initialised by the sweep
  always_ff @(posedge clk) begin
    bhr_q <= bhr_d;
    pht_q <= pht_d;
  end
endmodule

// File: tb/tb_branch_predictor_2lvl.sv
// tb_branch_predictor_2lvl: scoreboard bench for the two-level branch predictor
module tb_branch_predictor_2lvl;
  logic        clk = 1'b0;
  logic        rst = 1'b0, flush = 1'b0, busy;
  logic [31:0] pred_pc = '0, pred_target;
  logic        pred_taken, pred_hit;
  logic        upd_valid = 1'b0, upd_is_jal = 1'b0, upd_taken = 1'b0, upd_pred_taken = 1'b0;
  logic [31:0] upd_pc = '0, upd_target = '0;
  logic [15:0] stat_branches, stat_mispred;

  branch_predictor_2lvl dut (
    .clk(clk), .rst(rst), .flush(flush), .busy(busy),
    .pred_pc(pred_pc), .pred_taken(pred_taken), .pred_hit(pred_hit), .pred_target(pred_target),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_is_jal(upd_is_jal), .upd_taken(upd_taken),
    .upd_target(upd_target), .upd_pred_taken(upd_pred_taken),
    .stat_branches(stat_branches), .stat_mispred(stat_mispred)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    logic        t;
    logic        h;
    logic [31:0] tg;
  } exp_t;
  exp_t sb[$];
  exp_t e;
  int n_vec = 0, n_err = 0;

  int          m_bhr [16];
  int          m_pht [16];
  bit          m_bv  [16];
  bit          m_jal [16];
  int          m_tag [16];
  logic [31:0] m_tgt [16];
  int          m_br = 0, m_mis = 0;

  function automatic void m_clear();
    for (int k = 0; k < 16; k++) begin
      m_bhr[k] = 0;
      m_pht[k] = 1;
      m_bv[k]  = 1'b0;
    end
  endfunction

  function automatic exp_t m_pred(input logic [31:0] pc, input string nm);
    exp_t r;
    int i, p;
    i = int'(pc[5:2]);
    p = i ^ m_bhr[i];
    r.nm = nm;
    r.h  = m_bv[i] && (m_tag[i] == int'(pc[13:6]));
    r.t  = r.h && (m_jal[i] || m_pht[p] >= 2);
    r.tg = m_tgt[i];
    return r;
  endfunction

  function automatic void m_upd(input logic [31:0] pc, input logic jal, input logic tk,
                                input logic [31:0] tgt, input logic ptk);
    int i, p;
    i = int'(pc[5:2]);
    p = i ^ m_bhr[i];
    if (!jal) begin
      m_pht[p] = tk ? ((m_pht[p] < 3) ? m_pht[p] + 1 : 3) : ((m_pht[p] > 0) ? m_pht[p] - 1 : 0);
      m_bhr[i] = ((m_bhr[i] << 1) | int'(tk)) & 15;
      m_br++;
      if (tk != ptk) m_mis++;
    end
    if (tk) begin
      m_bv[i]  = 1'b1;
      m_jal[i] = jal;
      m_tag[i] = int'(pc[13:6]);
      m_tgt[i] = tgt;
    end
  endfunction

  task automatic probe(input logic [31:0] pc, input string nm);
    pred_pc = pc;
    sb.push_back(m_pred(pc, nm));
  endtask

  task automatic upd(input logic [31:0] pc, input logic jal, input logic tk,
                     input logic [31:0] tgt, input logic ptk);
    @(negedge clk);
    upd_pc = pc; upd_is_jal = jal; upd_taken = tk; upd_target = tgt; upd_pred_taken = ptk;
    upd_valid = 1'b1;
    m_upd(pc, jal, tk, tgt, ptk);
    @(negedge clk);
    upd_valid = 1'b0;
  endtask

  task automatic test_reset();
    int cnt;
    logic [31:0] pcs [4];
    pcs = '{32'h0, 32'h40, 32'h100, 32'h3fc};
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_clear();
    m_br = 0;
    m_mis = 0;
    cnt = 0;
    while (busy === 1'b1 && cnt < 100) begin
      cnt++;
      @(negedge clk);
    end
    n_vec++;
    if (cnt != 16) begin
      n_err++;
      $display("FAIL reset_busy_len: got %0d cycles, want 16", cnt);
    end
    foreach (pcs[k]) begin
      probe(pcs[k], "reset_lookup");
      #1 e = sb.pop_front();
      n_vec++;
      if (pred_taken !== e.t || pred_hit !== e.h || (e.h && pred_target !== e.tg)) begin
        n_err++;
        $display("FAIL %s: got t=%b h=%b tg=%h, want t=%b h=%b tg=%h", e.nm, pred_taken, pred_hit, pred_target, e.t, e.h, e.tg);
      end
      @(negedge clk);
    end
    n_vec++;
    if (stat_branches !== 16'd0 || stat_mispred !== 16'd0) begin
      n_err++;
      $display("FAIL reset_stats: got br=%0d mis=%0d, want 0 0", stat_branches, stat_mispred);
    end
  endtask

  task automatic test_training();
    for (int k = 0; k < 6; k++) begin
      upd(32'h40, 1'b0, 1'b1, 32'h80, 1'b0);
      probe(32'h40, "train_lookup");
      #1 e = sb.pop_front();
      n_vec++;
      if (pred_taken !== e.t || pred_hit !== e.h || (e.h && pred_target !== e.tg)) begin
        n_err++;
        $display("FAIL %s[%0d]: got t=%b h=%b tg=%h, want t=%b h=%b tg=%h", e.nm, k, pred_taken, pred_hit, pred_target, e.t, e.h, e.tg);
      end
    end
    n_vec++;
    if (stat_branches !== 16'(m_br)) begin
      n_err++;
      $display("FAIL train_stat_branches: got %0d, want %0d", stat_branches, m_br);
    end
  endtask

  task automatic test_saturation();
    for (int k = 0; k < 8; k++) begin
      upd(32'h40, 1'b0, 1'b0, 32'h80, 1'b1);
      probe(32'h40, "sat_lookup");
      #1 e = sb.pop_front();
      n_vec++;
      if (pred_taken !== e.t || pred_hit !== e.h || (e.h && pred_target !== e.tg)) begin
        n_err++;
        $display("FAIL %s[%0d]: got t=%b h=%b tg=%h, want t=%b h=%b tg=%h", e.nm, k, pred_taken, pred_hit, pred_target, e.t, e.h, e.tg);
      end
    end
    n_vec++;
    if (stat_mispred !== 16'(m_mis) || stat_branches !== 16'(m_br)) begin
      n_err++;
      $display("FAIL sat_stats: got br=%0d mis=%0d, want br=%0d mis=%0d", stat_branches, stat_mispred, m_br, m_mis);
    end
  endtask

  task automatic test_jal();
    upd(32'h100, 1'b1, 1'b1, 32'h200, 1'b0);
    probe(32'h100, "jal_lookup");
    #1 e = sb.pop_front();
    n_vec++;
    if (pred_taken !== e.t || pred_hit !== e.h || (e.h && pred_target !== e.tg)) begin
      n_err++;
      $display("FAIL %s: got t=%b h=%b tg=%h, want t=%b h=%b tg=%h", e.nm, pred_taken, pred_hit, pred_target, e.t, e.h, e.tg);
    end
    n_vec++;
    if (stat_branches !== 16'(m_br)) begin
      n_err++;
      $display("FAIL jal_stat_branches: got %0d, want %0d", stat_branches, m_br);
    end
  endtask

  task automatic test_alias();
    logic [31:0] pcs [2];
    pcs = '{32'h440, 32'h40};
    upd(32'h40, 1'b0, 1'b1, 32'h80, 1'b0);
    foreach (pcs[k]) begin
      probe(pcs[k], "alias_lookup");
      #1 e = sb.pop_front();
      n_vec++;
      if (pred_taken !== e.t || pred_hit !== e.h || (e.h && pred_target !== e.tg)) begin
        n_err++;
        $display("FAIL %s[%h]: got t=%b h=%b tg=%h, want t=%b h=%b tg=%h", e.nm, pcs[k], pred_taken, pred_hit, pred_target, e.t, e.h, e.tg);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_no_bypass();
    @(negedge clk);
    probe(32'h40, "same_cycle_old");
    upd_pc = 32'h40; upd_is_jal = 1'b0; upd_taken = 1'b1; upd_target = 32'h88; upd_pred_taken = 1'b1;
    upd_valid = 1'b1;
    #1 e = sb.pop_front();
    n_vec++;
    if (pred_taken !== e.t || pred_hit !== e.h || (e.h && pred_target !== e.tg)) begin
      n_err++;
      $display("FAIL %s: got t=%b h=%b tg=%h, want t=%b h=%b tg=%h", e.nm, pred_taken, pred_hit, pred_target, e.t, e.h, e.tg);
    end
    m_upd(32'h40, 1'b0, 1'b1, 32'h88, 1'b1);
    @(negedge clk);
    upd_valid = 1'b0;
    probe(32'h40, "same_cycle_new");
    #1 e = sb.pop_front();
    n_vec++;
    if (pred_taken !== e.t || pred_hit !== e.h || (e.h && pred_target !== e.tg)) begin
      n_err++;
      $display("FAIL %s: got t=%b h=%b tg=%h, want t=%b h=%b tg=%h", e.nm, pred_taken, pred_hit, pred_target, e.t, e.h, e.tg);
    end
  endtask

  task automatic test_back_to_back();
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      upd_pc = 32'h1000 + 32'(k * 4); upd_is_jal = 1'b0; upd_taken = 1'(k != 3);
      upd_target = 32'h2000 + 32'(k * 16); upd_pred_taken = 1'b0;
      upd_valid = 1'b1;
      m_upd(upd_pc, 1'b0, upd_taken, upd_target, 1'b0);
    end
    @(negedge clk);
    upd_valid = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      probe(32'h1000 + 32'(k * 4), "b2b_lookup");
      #1 e = sb.pop_front();
      n_vec++;
      if (pred_taken !== e.t || pred_hit !== e.h || (e.h && pred_target !== e.tg)) begin
        n_err++;
        $display("FAIL %s[%0d]: got t=%b h=%b tg=%h, want t=%b h=%b tg=%h", e.nm, k, pred_taken, pred_hit, pred_target, e.t, e.h, e.tg);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_flush();
    int cnt;
    logic [31:0] pcs [3];
    pcs = '{32'h40, 32'h1004, 32'h100};
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    repeat (6) @(negedge clk);
    n_vec++;
    if (busy !== 1'b1) begin
      n_err++;
      $display("FAIL flush_busy_mid: got %b, want 1", busy);
    end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    m_clear();
    cnt = 0;
    while (busy === 1'b1 && cnt < 100) begin
      upd_pc = 32'h1004; upd_is_jal = 1'b0; upd_taken = 1'b1; upd_target = 32'h3000; upd_pred_taken = 1'b0;
      upd_valid = (cnt == 3);
      cnt++;
      @(negedge clk);
    end
    upd_valid = 1'b0;
    n_vec++;
    if (cnt != 16) begin
      n_err++;
      $display("FAIL flush_busy_len: got %0d cycles, want 16", cnt);
    end
    foreach (pcs[k]) begin
      probe(pcs[k], "flush_lookup");
      #1 e = sb.pop_front();
      n_vec++;
      if (pred_taken !== e.t || pred_hit !== e.h || (e.h && pred_target !== e.tg)) begin
        n_err++;
        $display("FAIL %s[%h]: got t=%b h=%b tg=%h, want t=%b h=%b tg=%h", e.nm, pcs[k], pred_taken, pred_hit, pred_target, e.t, e.h, e.tg);
      end
      @(negedge clk);
    end
    n_vec++;
    if (stat_branches !== 16'(m_br) || stat_mispred !== 16'(m_mis)) begin
      n_err++;
      $display("FAIL flush_stats: got br=%0d mis=%0d, want br=%0d mis=%0d", stat_branches, stat_mispred, m_br, m_mis);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_training();
    test_saturation();
    test_jal();
    test_alias();
    test_no_bypass();
    test_back_to_back();
    test_flush();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
